// File: rtl/led_bank_arbiter.sv
// Round-robin owner of one shared LED bank: the granted requester's pattern is driven
// onto the bank, a blank cycle separates owners, and a hold timer bounds ownership under contention.
module led_bank_arbiter #(
  parameter int NO_OF_LEDS  = 4,
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NO_OF_LEDS-1:0]   req_pattern,
  output logic [NUM_REQ-1:0]              grant,
  output logic [$clog2(NUM_REQ)-1:0]      owner,
  output logic                            busy,
  output logic [NO_OF_LEDS-1:0]           led_out
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_q, last_d;
  logic [NO_OF_LEDS-1:0] led_q, led_d;
  logic [CW-1:0]         hold_q, hold_d;

  logic [OW-1:0]         cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]    cand_hit;
  logic [NO_OF_LEDS-1:0] pat [NUM_REQ];
  logic                  win_valid;
  logic [OW-1:0]         win_idx;
  logic                  others_req;

  // Candidate gi is the requester gi+1 places after the last owner, wrapped mod NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [OW:0] sum;
    assign sum          = {1'b0, last_q} + (OW+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (OW+1)'(NUM_REQ)) ? OW'(sum - (OW+1)'(NUM_REQ)) : sum[OW-1:0];
    assign cand_hit[gi] = req[cand_idx[gi]];
    assign pat[gi]      = req_pattern[gi*NO_OF_LEDS +: NO_OF_LEDS];
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign others_req = |(req & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    led_d   = led_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        led_d   = '0;
        grant_d = '0;
        if (win_valid) begin
          state_d          = S_OWN;
          owner_d          = win_idx;
          last_d           = win_idx;
          grant_d[win_idx] = 1'b1;
          hold_d           = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN: begin
        led_d = pat[owner_q];
        if (hold_q != CW'(HOLD_CYCLES)) begin
          hold_d = hold_q + CW'(1);
        end
        // Release is checked first so a leaving owner never counts as preempted.
        if (!req[owner_q]) begin
          state_d = S_GAP;
          grant_d = '0;
        end else if ((hold_q == CW'(HOLD_CYCLES)) && others_req) begin
          state_d = S_GAP;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      led_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = (state_q == S_OWN);
  assign led_out = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: reset, single owner, first arbitration,
// preemption timing, round-robin rotation and reset during ownership.
module tb_led_bank_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [11:0] req_pattern;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  led_out;

  int n_checks = 0;
  int n_fail   = 0;

  led_bank_arbiter #(.NO_OF_LEDS(4), .NUM_REQ(3), .HOLD_CYCLES(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_pattern (req_pattern),
    .grant       (grant),
    .owner       (owner),
    .busy        (busy),
    .led_out     (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", tag, obs, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pats [3];
    logic [2:0] exp_g;
    logic [3:0] exp_l;
    int phase, own;
    pats[0] = 4'h5;
    pats[1] = 4'hA;
    pats[2] = 4'hC;

    resetn      = 1'b0;
    req         = 3'b111;
    req_pattern = {4'hC, 4'hA, 4'h5};

    // Reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_grant", grant, 3'b000);
      check("rst_busy", busy, 1'b0);
      check("rst_led", led_out, 4'h0);
      check("rst_owner", owner, 2'd0);
    end

    // Single requester 1
    resetn = 1'b1;
    req    = 3'b010;
    tick();
    check("single_grant", grant, 3'b010);
    check("single_owner", owner, 2'd1);
    check("single_busy", busy, 1'b1);
    check("single_led_lag", led_out, 4'h0);
    tick();
    check("single_led", led_out, 4'hA);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("sole_hold_grant", grant, 3'b010);
    end
    req = 3'b000;
    tick();
    check("release_grant", grant, 3'b000);
    check("release_busy", busy, 1'b0);
    check("release_led_still", led_out, 4'hA);
    tick();
    check("gap_led", led_out, 4'h0);
    check("gap_grant", grant, 3'b000);
    tick();
    check("idle_grant", grant, 3'b000);
    check("idle_led", led_out, 4'h0);

    // Simultaneous first request after reset: requester 0 wins
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req    = 3'b101;
    tick();
    check("first_grant", grant, 3'b001);
    check("first_owner", owner, 2'd0);

    // Preemption by requester 2 after the hold window
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("preempt_hold_grant", grant, 3'b001);
      check("preempt_hold_led", led_out, 4'h5);
    end
    tick();
    check("preempt_gap_grant", grant, 3'b000);
    check("preempt_gap_busy", busy, 1'b0);
    tick();
    check("preempt_new_grant", grant, 3'b100);
    check("preempt_new_owner", owner, 2'd2);
    check("preempt_blank_led", led_out, 4'h0);
    tick();
    check("preempt_new_led", led_out, 4'hC);

    // Round robin with all requesting: 9 owned edges then one gap edge per owner
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req    = 3'b111;
    for (int t = 0; t < 40; t++) begin
      tick();
      phase = t % 10;
      own   = (t / 10) % 3;
      exp_g = (phase == 9) ? 3'b000 : 3'(1 << own);
      exp_l = (phase == 0) ? 4'h0 : pats[own];
      check("rr_grant", grant, exp_g);
      check("rr_led", led_out, exp_l);
    end

    // Reset in the middle of requester 1's ownership
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req    = 3'b010;
    tick();
    check("mid_pre_grant", grant, 3'b010);
    tick();
    check("mid_pre_led", led_out, 4'hA);
    resetn = 1'b0;
    tick();
    check("mid_rst_grant", grant, 3'b000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_led", led_out, 4'h0);
    check("mid_rst_owner", owner, 2'd0);
    resetn = 1'b1;
    req    = 3'b011;
    tick();
    check("mid_next_grant", grant, 3'b001);
    check("mid_next_owner", owner, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
# led_bank_arbiter

Round-robin arbiter that shares one bank of `NO_OF_LEDS` status LEDs between `NUM_REQ` requesters; each requester supplies its own LED pattern. The block grants ownership to one requester at a time and drives the winner's pattern onto the bank. A bounded hold time lets a waiting requester preempt the current owner. It sits between the LED-producing blocks (counters, status monitors) and the board LED pins.

## Interface
- `NO_OF_LEDS`, 4, width of the LED bank and of each pattern.
- `NUM_REQ`, 3, number of requesters; legal range 2..8.
- `HOLD_CYCLES`, 8, minimum owned cycles before preemption is allowed; must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset: synchronous, active-low.
- `req`  in  `NUM_REQ`  per-requester ownership request; level-sensitive.
- `req_pattern`  in  `NUM_REQ*NO_OF_LEDS`  pattern of requester i at bits `[i*NO_OF_LEDS +: NO_OF_LEDS]`.
- `grant`  out  `NUM_REQ`  one-hot current owner, or all zero; registered.
- `owner`  out  `$clog2(NUM_REQ)`  index of current owner; valid only while `busy`=1.
- `busy`  out  1  high in OWN state.
- `led_out`  out  `NO_OF_LEDS`  registered LED drive.

## Operation
- States: IDLE, OWN, GAP.
- Reset values: state=IDLE, `grant`=0, `owner`=0, `busy`=0, `led_out`=0, hold counter=0, `last_owner`=`NUM_REQ`-1, so requester 0 wins the first arbitration.
- Arbitration runs in IDLE and GAP. It selects the first requester with `req`=1, searching from `last_owner`+1 upward and wrapping mod `NUM_REQ`.
- **IDLE**
  - Any `req` set: go to OWN; load `owner`/`last_owner` with the winner; set `grant` one-hot; clear the hold counter.
  - No `req` set: stay in IDLE; `led_out`<=0.
- **OWN**
  - Each cycle: `led_out` <= pattern slice of `owner`.
  - Hold counter increments by 1 and saturates at `HOLD_CYCLES`.
  - Release: `req[owner]`=0 moves to GAP. This has priority over preemption.
  - Preempt: counter==`HOLD_CYCLES` and any other `req` bit set moves to GAP.
  - Otherwise stay in OWN. A sole requester keeps ownership indefinitely.
- **GAP**
  - Lasts exactly one cycle; `grant`=0, `busy`=0, `led_out`<=0 (blank cycle between owners).
  - Then arbitrate as in IDLE: go to OWN with the winner, or to IDLE if no `req` is set.
  - The previous owner is lowest priority because `last_owner` was updated at grant.
- `req` bits of non-owners are ignored in OWN except for the preemption check.
- `req_pattern` of non-owners is ignored.
- `resetn`=0 in any state, including mid-ownership, forces all reset values at the next edge.

## Timing
- `req` is sampled at edge E in IDLE → `grant`/`busy`/`owner` valid after E.
- The first owner pattern appears on `led_out` after E+1. `led_out` always lags `req_pattern` by one cycle.
- Release: `req[owner]`=0 sampled at edge R → `grant`=0 after R. `led_out` is 0 after R+1, i.e. the GAP cycle's edge.
- After release or preemption at edge R, the next grant is valid after R+1.
- Preemption timing: owned cycles are counted from the grant edge. The earliest preempting transition is the edge at which the counter already equals `HOLD_CYCLES`, which is `HOLD_CYCLES`+1 edges after grant.
- `grant` is never multi-hot. `busy` equals `|grant`.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles with `req`=3'b111 → `grant`=0, `busy`=0, `led_out`=0, `owner`=0 throughout.
- **Single requester:** `req`=3'b010, pattern1=4'hA.
  - `grant`=3'b010 and `owner`=1 one edge later; `led_out`=4'hA the edge after that.
  - Then drop `req` → `grant`=0 the next edge, `led_out`=0 the edge after; state returns to IDLE.
- **Simultaneous first request:** `req`=3'b101 right after reset → `grant`=3'b001 (requester 0 wins).
- **Preemption:** requester 0 owns with pattern 4'h5; assert `req[2]` with pattern 4'hC.
  - Ownership is held for 9 edges after the grant, then one GAP cycle with `led_out`=0.
  - Then `grant`=3'b100 and `led_out`=4'hC.
- **Round robin:** hold `req`=3'b111 for 40 cycles → grant sequence 001,010,100,001,… with one zero-grant cycle between owners.
- **Reset mid-ownership:** pulse `resetn`=0 for 1 cycle while requester 1 owns → all outputs 0 after the edge. The next grant goes to requester 0 if `req`=3'b011.
